// File: rtl/pattern_ctrl_pkg.sv
// Shared constants and state encoding for the pattern sequencing controller.
package pattern_ctrl_pkg;

    localparam int unsigned PATTERN_W = 3;

    localparam logic [PATTERN_W-1:0] PAT_FRAME_GREY = 3'd0;
    localparam logic [PATTERN_W-1:0] PAT_V_BARS     = 3'd1;
    localparam logic [PATTERN_W-1:0] PAT_H_BARS     = 3'd2;
    localparam logic [PATTERN_W-1:0] PAT_RAMP       = 3'd3;
    localparam logic [PATTERN_W-1:0] PAT_RANDOM     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/frame_edge_det.sv
// Frame boundary detector: a boundary is a 1->0 transition of vsync.
module frame_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic fs_c
);

    logic vs_d;

    // Delay vsync by one cycle for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= vs;
        end
    end

    assign fs_c = ~vs & vs_d;

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Frame-synchronous pattern select controller with command and auto-cycle paths.
module pattern_seq_ctrl
    import pattern_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS    = 5,
    parameter int unsigned DWELL_WIDTH     = 8,
    parameter int unsigned DEFAULT_DWELL   = 60,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       in_pclk,
    input  logic                       in_rst,
    input  logic                       in_vs,
    input  logic                       in_auto_en,
    input  logic                       in_cmd_valid,
    output logic                       out_cmd_ready,
    input  logic [PATTERN_W-1:0]       in_cmd_pattern,
    input  logic [DWELL_WIDTH-1:0]     in_cmd_dwell,
    output logic [PATTERN_W-1:0]       out_pattern,
    output logic                       out_pattern_update,
    output logic                       out_frame_start,
    output logic [FRAME_CNT_WIDTH-1:0] out_frame_cnt,
    output logic                       out_cmd_err
);

    localparam int unsigned CODE_W = PATTERN_W + 1;
    localparam logic [CODE_W-1:0]    NUM_PAT  = CODE_W'(NUM_PATTERNS);
    localparam logic [PATTERN_W-1:0] LAST_PAT = PATTERN_W'(NUM_PATTERNS - 1);

    state_t                       state, state_nx;
    logic                         fs;
    logic                         accept, illegal;
    logic [PATTERN_W-1:0]         pattern_nx;
    logic                         update_nx, frame_start_nx, err_nx, ready_nx;
    logic [FRAME_CNT_WIDTH-1:0]   frame_cnt_nx;
    logic [DWELL_WIDTH-1:0]       dwell_cnt, dwell_cnt_nx;
    logic [DWELL_WIDTH-1:0]       dwell_lim, dwell_lim_nx;
    logic [PATTERN_W-1:0]         cmd_pat, cmd_pat_nx;
    logic [DWELL_WIDTH-1:0]       cmd_dwell, cmd_dwell_nx;

    frame_edge_det u_edge (
        .clk  (in_pclk),
        .rst  (in_rst),
        .vs   (in_vs),
        .fs_c (fs)
    );

    assign accept  = in_cmd_valid & out_cmd_ready;
    assign illegal = {1'b0, in_cmd_pattern} >= NUM_PAT;

    // State register.
    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and registered-output values; a boundary uses the command held
    // before this cycle, so a coincident accept waits for the next boundary.
    always_comb begin
        state_nx       = state;
        pattern_nx     = out_pattern;
        update_nx      = 1'b0;
        frame_start_nx = 1'b0;
        frame_cnt_nx   = out_frame_cnt;
        err_nx         = 1'b0;
        dwell_cnt_nx   = dwell_cnt;
        dwell_lim_nx   = dwell_lim;
        cmd_pat_nx     = cmd_pat;
        cmd_dwell_nx   = cmd_dwell;

        if (fs) begin
            frame_start_nx = 1'b1;
            frame_cnt_nx   = out_frame_cnt + FRAME_CNT_WIDTH'(1);
            unique case (state)
                IDLE: state_nx = RUN;
                PEND: begin
                    pattern_nx   = cmd_pat;
                    dwell_lim_nx = cmd_dwell;
                    dwell_cnt_nx = '0;
                    update_nx    = 1'b1;
                    state_nx     = RUN;
                end
                RUN: begin
                    if (in_auto_en && (dwell_lim != '0) &&
                        (dwell_cnt == dwell_lim - DWELL_WIDTH'(1))) begin
                        pattern_nx   = (out_pattern == LAST_PAT) ? '0
                                                                 : out_pattern + PATTERN_W'(1);
                        dwell_cnt_nx = '0;
                        update_nx    = 1'b1;
                    end else if (dwell_cnt != '1) begin
                        dwell_cnt_nx = dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (accept) begin
            cmd_pat_nx   = illegal ? LAST_PAT : in_cmd_pattern;
            cmd_dwell_nx = in_cmd_dwell;
            err_nx       = illegal;
            state_nx     = PEND;
        end

        ready_nx = (state_nx != PEND);
    end

    // Output and datapath registers.
    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            out_pattern        <= '0;
            out_pattern_update <= 1'b0;
            out_frame_start    <= 1'b0;
            out_frame_cnt      <= '0;
            out_cmd_err        <= 1'b0;
            out_cmd_ready      <= 1'b1;
            dwell_cnt          <= '0;
            dwell_lim          <= DWELL_WIDTH'(DEFAULT_DWELL);
            cmd_pat            <= '0;
            cmd_dwell          <= '0;
        end else begin
            out_pattern        <= pattern_nx;
            out_pattern_update <= update_nx;
            out_frame_start    <= frame_start_nx;
            out_frame_cnt      <= frame_cnt_nx;
            out_cmd_err        <= err_nx;
            out_cmd_ready      <= ready_nx;
            dwell_cnt          <= dwell_cnt_nx;
            dwell_lim          <= dwell_lim_nx;
            cmd_pat            <= cmd_pat_nx;
            cmd_dwell          <= cmd_dwell_nx;
        end
    end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl: directed scenarios plus random frames.
module tb_pattern_seq_ctrl;

    localparam int NP  = 5;
    localparam int DW  = 8;
    localparam int FW  = 16;
    localparam int DEF = 60;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs = 1'b0;
    logic          auto_en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_pattern = 3'd0;
    logic [DW-1:0] cmd_dwell = '0;
    logic [2:0]    pattern;
    logic          update;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;
    logic          cmd_err;

    always #5 clk = ~clk;

    pattern_seq_ctrl #(
        .NUM_PATTERNS    (NP),
        .DWELL_WIDTH     (DW),
        .DEFAULT_DWELL   (DEF),
        .FRAME_CNT_WIDTH (FW)
    ) dut (
        .in_pclk            (clk),
        .in_rst             (rst),
        .in_vs              (vs),
        .in_auto_en         (auto_en),
        .in_cmd_valid       (cmd_valid),
        .out_cmd_ready      (cmd_ready),
        .in_cmd_pattern     (cmd_pattern),
        .in_cmd_dwell       (cmd_dwell),
        .out_pattern        (pattern),
        .out_pattern_update (update),
        .out_frame_start    (frame_start),
        .out_frame_cnt      (frame_cnt),
        .out_cmd_err        (cmd_err)
    );

    typedef struct {
        int pat;
        int upd;
        int cnt;
    } frame_exp_t;

    frame_exp_t frame_q[$];
    int         rdy_q[$];
    int         err_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int hold_pat = 0;
    int err_pipe = 0;

    // Reference model state
    bit m_pend, m_started, vs_prev;
    int m_pat, m_lim, m_cnt, m_fcnt, p_pat, p_dwell;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pend = 0; m_started = 0; vs_prev = 0;
        m_pat = 0; m_lim = DEF; m_cnt = 0; m_fcnt = 0;
        p_pat = 0; p_dwell = 0;
    endfunction

    // Predict the effect of the inputs about to be sampled; returns 1 on accept.
    function automatic bit model_step();
        bit fs, acc;
        int upd;
        frame_exp_t e;
        fs  = !vs && vs_prev;
        acc = cmd_valid && !m_pend;
        rdy_q.push_back(m_pend ? 0 : 1);
        err_q.push_back((acc && int'(cmd_pattern) >= NP) ? 1 : 0);
        vs_prev = vs;
        if (fs) begin
            upd = 0;
            m_fcnt = (m_fcnt + 1) % (1 << FW);
            if (m_pend) begin
                m_pat = p_pat; m_lim = p_dwell; m_cnt = 0; upd = 1; m_pend = 0;
            end else if (m_started) begin
                if (auto_en && m_lim != 0 && m_cnt == m_lim - 1) begin
                    m_pat = (m_pat + 1) % NP; m_cnt = 0; upd = 1;
                end else if (m_cnt < (1 << DW) - 1) begin
                    m_cnt++;
                end
            end
            m_started = 1;
            e.pat = m_pat; e.upd = upd; e.cnt = m_fcnt;
            frame_q.push_back(e);
        end
        if (acc) begin
            m_pend  = 1;
            p_pat   = (int'(cmd_pattern) >= NP) ? NP - 1 : int'(cmd_pattern);
            p_dwell = int'(cmd_dwell);
        end
        return acc;
    endfunction

    task automatic tick();
        bit acc;
        acc = model_step();
        @(posedge clk);
        #1;
        if (acc) cmd_valid = 1'b0;
    endtask

    // One frame: vs high for hi cycles then low for lo; optional command at index cmd_at.
    task automatic frame(int hi, int lo, int cmd_at, int cp, int cd);
        for (int i = 0; i < hi + lo; i++) begin
            vs = (i < hi);
            if (i == cmd_at && !cmd_valid) begin
                cmd_valid   = 1'b1;
                cmd_pattern = 3'(cp);
                cmd_dwell   = DW'(cd);
            end
            tick();
        end
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) frame(2, 2, -1, 0, 0);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("frames_outstanding", frame_q.size(), 0);
        frame_q.delete();
        rdy_q.delete();
        err_q.delete();
        model_reset();
        chk("rst_pattern", int'(pattern), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        hold_pat = 0;
        err_pipe = 0;
        mon_en   = 1'b1;
    endtask

    // Monitor: per-cycle ready/err checks and per-frame_start pattern checks.
    always @(negedge clk) begin
        frame_exp_t e;
        if (mon_en) begin
            chk("cmd_err", int'(cmd_err), err_pipe);
            err_pipe = 0;
            if (rdy_q.size() > 0) begin
                chk("cmd_ready", int'(cmd_ready), rdy_q.pop_front());
                err_pipe = err_q.pop_front();
            end
            if (frame_start) begin
                if (frame_q.size() == 0) begin
                    chk("unexpected_frame_start", 1, 0);
                end else begin
                    e = frame_q.pop_front();
                    chk("pattern", int'(pattern), e.pat);
                    chk("pattern_update", int'(update), e.upd);
                    chk("frame_cnt", int'(frame_cnt), e.cnt);
                    hold_pat = e.pat;
                end
            end else begin
                chk("pattern_hold", int'(pattern), hold_pat);
                chk("update_outside_boundary", int'(update), 0);
            end
        end
    end

    initial begin
        int hi, lo, at;
        model_reset();
        do_reset();

        // No commands, auto off: pattern stays 0 while frames count.
        auto_en = 1'b0;
        frames(3);
        tick();
        chk("t1_frame_cnt", int'(frame_cnt), 3);

        // Dwell of 2 with auto-cycle.
        auto_en = 1'b1;
        frame(3, 3, 1, 0, 2);
        frames(11);

        // Pattern 3 with dwell 0 holds despite auto.
        frame(3, 3, 1, 3, 0);
        frames(20);

        // Command coincident with a boundary, then a second one stalled behind it.
        frame(3, 3, 3, 1, 5);
        frame(3, 3, 0, 2, 1);
        frames(3);

        // Illegal code clamps to the last pattern.
        frame(3, 3, 1, 7, 9);
        frames(2);

        // Dwell counter saturates with auto off; re-enabling auto then holds.
        auto_en = 1'b0;
        frame(2, 2, 0, 1, 3);
        for (int i = 0; i < 260; i++) frame(1, 1, -1, 0, 0);
        auto_en = 1'b1;
        frames(5);
        frame(2, 2, 0, 2, 3);
        frames(4);

        // Reset while a command is pending and vs is low.
        frame(3, 4, 4, 2, 1);
        do_reset();
        frames(3);

        // Randomized frames and commands.
        for (int f = 0; f < 200; f++) begin
            hi = int'($urandom_range(1, 4));
            lo = int'($urandom_range(1, 6));
            at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
            auto_en = ($urandom_range(0, 3) != 0);
            frame(hi, lo, at, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        vs = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("frames_drained", frame_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
